level_fifo: RTL
===============

LEVEL_FIFO -- requirements
Module: level_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 256, number of storage words; any value 2..2^ADDR_WIDTH.
REQ-003 SHALL have parameter ADDR_WIDTH, default 8, pointer width.
REQ-004 SHALL have parameter STROBE_MODE, default 1: 1 = falling edge of write/read is a request; 0 = each clock with write/read high is a request.
REQ-005 SHALL have parameter AF_THRESH, default DEPTH-4, almost-full threshold, range 1..DEPTH.
REQ-006 SHALL have parameter AE_THRESH, default 4, almost-empty threshold, range 0..DEPTH-1.
REQ-007 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-008 SHALL have port reset, input, 1; asynchronous, active-high.
REQ-009 SHALL have port flush, input, 1, synchronous clear.
REQ-010 SHALL have port d, input, WIDTH, write data.
REQ-011 SHALL have port write, input, 1, write strobe/level per STROBE_MODE.
REQ-012 SHALL have port read, input, 1, read strobe/level per STROBE_MODE.
REQ-013 SHALL have port q, output, WIDTH, head-of-queue word (show-ahead).
REQ-014 SHALL have ports empty, full, lastbyte, almost_empty, almost_full: outputs, 1 bit each.
REQ-015 SHALL have port level, output, ADDR_WIDTH+1, current occupancy 0..DEPTH.
REQ-016 SHALL have ports overflow, underflow: outputs, 1 bit each, sticky error flags.

Function
REQ-017 STROBE_MODE=1: wr_req = prev_write & ~write, rd_req = prev_read & ~read; prev_* registered every clk.
REQ-018 STROBE_MODE=0: wr_req = write, rd_req = read, sampled at each rising clk edge.
REQ-019 Write accepted when wr_req and (level<DEPTH or rd_req accepted same cycle): mem[waddr]<=d, waddr advances.
REQ-020 Read accepted when rd_req and level>0: raddr advances; no data bypass from a same-cycle write into an empty FIFO.
REQ-021 Pointers SHALL wrap from DEPTH-1 to 0 (modulo DEPTH, not 2^ADDR_WIDTH).
REQ-022 level: +1 on write only, -1 on read only, unchanged on both or neither.
REQ-023 Full with wr_req and rd_req: both accepted, level stays DEPTH, overflow not set.
REQ-024 Empty with wr_req and rd_req: write accepted, read rejected, level becomes 1, underflow set.
REQ-025 wr_req rejected (full, no read) SHALL drop d and set overflow; rd_req on empty SHALL set underflow.
REQ-026 overflow/underflow SHALL remain 1 until reset or flush.
REQ-027 q = mem[raddr], combinational from storage; valid only while empty=0; takes new head the cycle after a read is accepted.
REQ-028 empty = (level==0); full = (level==DEPTH); lastbyte = (level==1); almost_full = (level>=AF_THRESH); almost_empty = (level<=AE_THRESH); all decoded from the level register, with no extra latency.
REQ-029 flush SHALL zero raddr, waddr, level, overflow, underflow at the next edge and discard same-cycle requests; prev_* still updated.
REQ-030 Storage SHALL NOT be cleared by reset or flush; q is undefined while empty.

Reset
REQ-031 reset high SHALL immediately force raddr=0, waddr=0, level=0, prev_write=0, prev_read=0, overflow=0, underflow=0, regardless of clk.
REQ-032 During and after reset: empty=1, full=0, lastbyte=0, almost_empty=1, almost_full=0, level=0.
REQ-033 reset asserted mid-transfer SHALL discard all queued data; no request is taken on the edge at which reset is still high.
REQ-034 STROBE_MODE=1 with write held high through reset release: exactly one write on its subsequent falling edge.

Verification (DEPTH=4, WIDTH=8, AF_THRESH=3, AE_THRESH=1)
REQ-035 Reset, then 4 write strobes d=0x11,0x22,0x33,0x44 -> level 1,2,3,4; almost_full at 3; full=1 at 4; q=0x11.
REQ-036 From full, 5th write 0x55 -> level 4, overflow=1; four reads yield q=0x11,0x22,0x33,0x44, then empty=1.
REQ-037 Read on empty -> underflow=1, level 0; flush -> underflow=0, overflow=0.
REQ-038 Mode 0, full, write=read=1 for 6 clocks -> level stays 4, no overflow; pointers wrap; output order preserved.
REQ-039 Empty, simultaneous read+write 0xA5 -> level 1, lastbyte=1, q=0xA5, underflow=1.
REQ-040 Assert reset asynchronously between edges with level=3 -> level=0, empty=1 before the next clk edge.

Source files
------------

// File: rtl/level_fifo.sv
`default_nettype none
// ============================================================================
// Module   : level_fifo
// Summary  : Single-clock show-ahead FIFO with occupancy level, threshold flags,
//            edge- or level-triggered requests and sticky overflow/underflow.
// Revision : 1.0
// ============================================================================
module level_fifo #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 256,
  parameter int ADDR_WIDTH  = 8,
  parameter int STROBE_MODE = 1,
  parameter int AF_THRESH   = DEPTH - 4,
  parameter int AE_THRESH   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [WIDTH-1:0]      d,
  input  logic                  write,
  input  logic                  read,
  output logic [WIDTH-1:0]      q,
  output logic                  empty,
  output logic                  full,
  output logic                  lastbyte,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int                  IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] FULL_LVL  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_LVL    = (ADDR_WIDTH + 1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_LVL    = (ADDR_WIDTH + 1)'(AE_THRESH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [ADDR_WIDTH-1:0] raddr;
  logic [ADDR_WIDTH-1:0] waddr;
  logic                  prev_write;
  logic                  prev_read;
  logic                  wr_req;
  logic                  rd_req;
  logic                  wr_ok;
  logic                  rd_ok;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [ADDR_WIDTH-1:0] bump(input logic [ADDR_WIDTH-1:0] p);
    return (p == LAST_ADDR) ? '0 : p + 1'b1;
  endfunction

  generate
    if (STROBE_MODE != 0) begin : g_edge_req
      assign wr_req = prev_write & ~write;
      assign rd_req = prev_read  & ~read;
    end else begin : g_level_req
      assign wr_req = write;
      assign rd_req = read;
    end
  endgenerate

  // A full FIFO still takes a write when a read frees a slot on the same edge.
  always_comb begin
    rd_ok = 1'b0;
    wr_ok = 1'b0;
    rd_ok = rd_req && (level != '0);
    wr_ok = wr_req && ((level != FULL_LVL) || rd_ok);
  end

  always_ff @(posedge clk) begin
    if (wr_ok && !flush && !reset) begin
      mem[waddr[IDX_W-1:0]] <= d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      raddr      <= '0;
      waddr      <= '0;
      level      <= '0;
      prev_write <= 1'b0;
      prev_read  <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      prev_write <= write;
      prev_read  <= read;
      if (flush) begin
        raddr     <= '0;
        waddr     <= '0;
        level     <= '0;
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end else begin
        if (wr_ok) begin
          waddr <= bump(waddr);
        end
        if (rd_ok) begin
          raddr <= bump(raddr);
        end
        case ({wr_ok, rd_ok})
          2'b10:   level <= level + 1'b1;
          2'b01:   level <= level - 1'b1;
          default: level <= level;
        endcase
        if (wr_req && !wr_ok) begin
          overflow <= 1'b1;
        end
        if (rd_req && (level == '0)) begin
          underflow <= 1'b1;
        end
      end
    end
  end

  assign q            = mem[raddr[IDX_W-1:0]];
  assign empty        = (level == '0);
  assign full         = (level == FULL_LVL);
  assign lastbyte     = (level == (ADDR_WIDTH + 1)'(1));
  assign almost_full  = (level >= AF_LVL);
  assign almost_empty = (level <= AE_LVL);

endmodule
`default_nettype wire
